matmul_2x2_sequencer: RTL and testbench

Job-level controller that sequences the 2x2 MAC array to compute C = A(2xK) * B(Kx2).
- Accepts a job descriptor (K) over a valid/ready handshake.
- Clears the array, then streams K operand beats into it, one beat per accepted handshake.
- After the final beat settles, presents the four accumulators as one result beat.
- Sits between the operand-fetch/DMA logic upstream and the MAC array; it is the only driver of the array's control and operand ports.

---
 rtl/matmul_pkg.sv | 39 +++
 rtl/matmul_2x2_sequencer.sv | 139 +++++++++++++
 tb/tb_matmul_2x2_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared types and default widths for the 2x2 matrix-multiply job sequencer.
package matmul_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ACC_WIDTH  = 20;
    localparam int DEF_K_WIDTH    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ACCUM = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_t;

    // Per-state control flags; the sequencer registers these alongside the state.
    typedef struct packed {
        logic start_ready;
        logic op_ready;
        logic mac_clear;
        logic res_valid;
        logic busy;
    } seq_flags_t;

    function automatic seq_flags_t flags_for(input seq_state_t s);
        seq_flags_t f;
        f = '0;
        case (s)
            IDLE:    f.start_ready = 1'b1;
            CLEAR:   begin f.mac_clear = 1'b1; f.busy = 1'b1; end
            ACCUM:   begin f.op_ready  = 1'b1; f.busy = 1'b1; end
            DRAIN:   f.busy = 1'b1;
            DONE:    begin f.res_valid = 1'b1; f.busy = 1'b1; end
            default: f = '0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/matmul_2x2_sequencer.sv
// Job-level controller for the 2x2 MAC array computing C = A(2xK) * B(Kx2).
// Accepts K, clears the array, streams K operand beats, waits one drain cycle,
// then presents the four accumulators as a single result beat.
// Optional build macro: MATMUL_SEQ_ABORT_EN adds an abort input that cancels a
// job in CLEAR/ACCUM/DRAIN and clears the array.
module matmul_2x2_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int K_WIDTH    = DEF_K_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    // job descriptor
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [K_WIDTH-1:0]    k_len,
`ifdef MATMUL_SEQ_ABORT_EN
    input  logic                  abort,
`endif
    // operand beats
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [DATA_WIDTH-1:0] a_r0,
    input  logic [DATA_WIDTH-1:0] a_r1,
    input  logic [DATA_WIDTH-1:0] b_c0,
    input  logic [DATA_WIDTH-1:0] b_c1,
    // MAC array control and operands
    output logic                  mac_enable,
    output logic                  mac_clear,
    output logic [DATA_WIDTH-1:0] mac_a_00,
    output logic [DATA_WIDTH-1:0] mac_a_01,
    output logic [DATA_WIDTH-1:0] mac_a_10,
    output logic [DATA_WIDTH-1:0] mac_a_11,
    output logic [DATA_WIDTH-1:0] mac_b_00,
    output logic [DATA_WIDTH-1:0] mac_b_01,
    output logic [DATA_WIDTH-1:0] mac_b_10,
    output logic [DATA_WIDTH-1:0] mac_b_11,
    input  logic [ACC_WIDTH-1:0]  acc_00,
    input  logic [ACC_WIDTH-1:0]  acc_01,
    input  logic [ACC_WIDTH-1:0]  acc_10,
    input  logic [ACC_WIDTH-1:0]  acc_11,
    // result beat
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  c_00,
    output logic [ACC_WIDTH-1:0]  c_01,
    output logic [ACC_WIDTH-1:0]  c_10,
    output logic [ACC_WIDTH-1:0]  c_11,
    output logic                  busy
);

    seq_state_t         r_state;
    seq_flags_t         r_flags;
    logic [K_WIDTH-1:0] r_count;
    logic [K_WIDTH-1:0] r_k;

    seq_state_t         w_state_next;
    logic               w_abort;
    logic               w_op_hs;
    logic               w_last_beat;
    logic               w_in_accum;

`ifdef MATMUL_SEQ_ABORT_EN
    // Abort only matters while a job is in flight; in IDLE and DONE it is ignored.
    assign w_abort = abort & ((r_state == CLEAR) | (r_state == ACCUM) | (r_state == DRAIN));
`else
    assign w_abort = 1'b0;
`endif

    assign w_in_accum  = r_flags.op_ready;
    // An abort wins over a simultaneous beat: the beat is neither accumulated nor counted.
    assign w_op_hs     = op_valid & r_flags.op_ready & ~w_abort;
    assign w_last_beat = (r_count == (r_k - K_WIDTH'(1)));

    // Next-state selection for the job FSM.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start_valid) w_state_next = CLEAR;
            CLEAR:   w_state_next = (r_k != '0) ? ACCUM : DRAIN;
            ACCUM:   if (w_op_hs && w_last_beat) w_state_next = DRAIN;
            DRAIN:   w_state_next = DONE;
            DONE:    if (res_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (w_abort) begin
            w_state_next = IDLE;
        end
    end

    // State, beat counter, latched K and registered per-state flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_flags <= flags_for(IDLE);
            r_count <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_next;
            r_flags <= flags_for(w_state_next);
            if (r_state == IDLE && start_valid) begin
                r_k <= k_len;
            end
            if (r_state == CLEAR) begin
                r_count <= '0;
            end else if (w_op_hs) begin
                r_count <= r_count + K_WIDTH'(1);
            end
        end
    end

    assign start_ready = r_flags.start_ready;
    assign op_ready    = r_flags.op_ready;
    assign res_valid   = r_flags.res_valid;
    assign busy        = r_flags.busy;

    // Enable fires in the handshake cycle so the array accumulates the beat on that edge.
    assign mac_enable  = w_op_hs;
    assign mac_clear   = r_flags.mac_clear | w_abort;

    // Row operand of A is shared along a row, column operand of B along a column.
    assign mac_a_00 = w_in_accum ? a_r0 : '0;
    assign mac_a_01 = w_in_accum ? a_r0 : '0;
    assign mac_a_10 = w_in_accum ? a_r1 : '0;
    assign mac_a_11 = w_in_accum ? a_r1 : '0;
    assign mac_b_00 = w_in_accum ? b_c0 : '0;
    assign mac_b_10 = w_in_accum ? b_c0 : '0;
    assign mac_b_01 = w_in_accum ? b_c1 : '0;
    assign mac_b_11 = w_in_accum ? b_c1 : '0;

    // The array is idle in DONE, so its accumulators are stable for the whole result beat.
    assign c_00 = r_flags.res_valid ? acc_00 : '0;
    assign c_01 = r_flags.res_valid ? acc_01 : '0;
    assign c_10 = r_flags.res_valid ? acc_10 : '0;
    assign c_11 = r_flags.res_valid ? acc_11 : '0;

endmodule

// File: tb/tb_matmul_2x2_sequencer.sv
// Directed self-checking bench for matmul_2x2_sequencer with a behavioural 2x2 MAC array.
// Build with MATMUL_SEQ_ABORT_EN defined to also exercise the abort path.
module tb_matmul_2x2_sequencer;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int KW = 8;

    logic          clock;
    logic          reset;
    logic          start_valid;
    logic          start_ready;
    logic [KW-1:0] k_len;
    logic          abort;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] a_r0, a_r1, b_c0, b_c1;
    logic          mac_enable, mac_clear;
    logic [DW-1:0] mac_a_00, mac_a_01, mac_a_10, mac_a_11;
    logic [DW-1:0] mac_b_00, mac_b_01, mac_b_10, mac_b_11;
    logic [AW-1:0] acc_00, acc_01, acc_10, acc_11;
    logic          res_valid, res_ready;
    logic [AW-1:0] c_00, c_01, c_10, c_11;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int enable_count = 0;
    int clear_count = 0;
    int op_ready_count = 0;

    matmul_2x2_sequencer #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_WIDTH(KW)) dut (
        .clock(clock), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready), .k_len(k_len),
`ifdef MATMUL_SEQ_ABORT_EN
        .abort(abort),
`endif
        .op_valid(op_valid), .op_ready(op_ready),
        .a_r0(a_r0), .a_r1(a_r1), .b_c0(b_c0), .b_c1(b_c1),
        .mac_enable(mac_enable), .mac_clear(mac_clear),
        .mac_a_00(mac_a_00), .mac_a_01(mac_a_01), .mac_a_10(mac_a_10), .mac_a_11(mac_a_11),
        .mac_b_00(mac_b_00), .mac_b_01(mac_b_01), .mac_b_10(mac_b_10), .mac_b_11(mac_b_11),
        .acc_00(acc_00), .acc_01(acc_01), .acc_10(acc_10), .acc_11(acc_11),
        .res_valid(res_valid), .res_ready(res_ready),
        .c_00(c_00), .c_01(c_01), .c_10(c_10), .c_11(c_11),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural MAC array: clear wins over enable, wraps modulo 2^AW.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_00 <= '0; acc_01 <= '0; acc_10 <= '0; acc_11 <= '0;
        end else if (mac_clear) begin
            acc_00 <= '0; acc_01 <= '0; acc_10 <= '0; acc_11 <= '0;
        end else if (mac_enable) begin
            acc_00 <= acc_00 + AW'(mac_a_00) * AW'(mac_b_00);
            acc_01 <= acc_01 + AW'(mac_a_01) * AW'(mac_b_01);
            acc_10 <= acc_10 + AW'(mac_a_10) * AW'(mac_b_10);
            acc_11 <= acc_11 + AW'(mac_a_11) * AW'(mac_b_11);
        end
    end

    // Cycle counter and event monitors sampled at the active edge.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (mac_enable) enable_count <= enable_count + 1;
        if (mac_clear)  clear_count  <= clear_count + 1;
        if (op_ready)   op_ready_count <= op_ready_count + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Present a job descriptor; returns in the CLEAR cycle.
    task automatic start_job(input int k);
        k_len = KW'(k);
        start_valid = 1'b1;
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL start_ready_idle: got %b expected 1", start_ready);
        end
        tick();
        start_cyc = cyc;
        start_valid = 1'b0;
        checks++;
        if (mac_clear !== 1'b1 || busy !== 1'b1 || op_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_cycle: got clear=%b busy=%b op_ready=%b expected 1 1 0",
                     mac_clear, busy, op_ready);
        end
    endtask

    // Idle gap cycles, then one operand beat held until accepted.
    task automatic send_beat(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                             input logic [DW-1:0] b0, input logic [DW-1:0] b1, input int gaps);
        int n;
        op_valid = 1'b0;
        for (int i = 0; i < gaps; i++) tick();
        a_r0 = a0; a_r1 = a1; b_c0 = b0; b_c1 = b1;
        op_valid = 1'b1;
        n = 0;
        while (op_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        #1;
        checks++;
        if (op_ready !== 1'b1 || mac_enable !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: got op_ready=%b enable=%b expected 1 1", op_ready, mac_enable);
        end
        checks++;
        if ({mac_a_00, mac_a_01, mac_a_10, mac_a_11, mac_b_00, mac_b_01, mac_b_10, mac_b_11}
            !== {a0, a0, a1, a1, b0, b1, b0, b1}) begin
            errors++;
            $display("FAIL routing: got a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d expected a=%0d,%0d,%0d,%0d b=%0d,%0d,%0d,%0d",
                     mac_a_00, mac_a_01, mac_a_10, mac_a_11, mac_b_00, mac_b_01, mac_b_10, mac_b_11,
                     a0, a0, a1, a1, b0, b1, b0, b1);
        end
        tick();
        op_valid = 1'b0;
        a_r0 = '0; a_r1 = '0; b_c0 = '0; b_c1 = '0;
    endtask

    // Wait (bounded) for res_valid and report edges since the start handshake.
    task automatic wait_result(output int lat);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        lat = cyc - start_cyc;
        if (res_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: res_valid still %b after %0d cycles", res_valid, n);
        end
    endtask

    // Take the result beat and confirm the return to IDLE.
    task automatic accept_result;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: got start_ready=%b busy=%b res_valid=%b expected 1 0 0",
                     start_ready, busy, res_valid);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start_valid = 1'b0; k_len = '0; abort = 1'b0; res_ready = 1'b0;
        op_valid = 1'b1; a_r0 = 8'd9; a_r1 = 8'd9; b_c0 = 8'd9; b_c1 = 8'd9;
        tick(); tick();
        checks++;
        if ({start_ready, op_ready, mac_enable, mac_clear, res_valid, busy} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_ctrl: got sr/or/en/clr/rv/busy=%b expected 100000",
                     {start_ready, op_ready, mac_enable, mac_clear, res_valid, busy});
        end
        checks++;
        if ({mac_a_00, mac_a_11, mac_b_00, mac_b_11} !== 32'd0 || {c_00, c_01, c_10, c_11} !== 80'd0) begin
            errors++;
            $display("FAIL reset_data: got a00=%0d b11=%0d c00=%0d expected 0", mac_a_00, mac_b_11, c_00);
        end
        reset = 1'b0;
        op_valid = 1'b0; a_r0 = '0; a_r1 = '0; b_c0 = '0; b_c1 = '0;
        tick();
        $display("reset: start_ready=%b busy=%b", start_ready, busy);
    endtask

    task automatic test_basic;
        int lat, en0;
        en0 = enable_count;
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 0);
        wait_result(lat);
        $display("basic k=2: c=%0d %0d %0d %0d latency=%0d", c_00, c_01, c_10, c_11, lat);
        checks++;
        if (lat != 4) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 4", lat);
        end
        checks++;
        if ({c_00, c_01, c_10, c_11} !== {20'd19, 20'd22, 20'd43, 20'd50}) begin
            errors++;
            $display("FAIL basic_c: got %0d %0d %0d %0d expected 19 22 43 50", c_00, c_01, c_10, c_11);
        end
        checks++;
        if (enable_count - en0 != 2) begin
            errors++;
            $display("FAIL basic_enables: got %0d expected 2", enable_count - en0);
        end
        accept_result();
    endtask

    task automatic test_stalls;
        int lat, en0;
        en0 = enable_count;
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 3);
        wait_result(lat);
        $display("stalls k=2: c=%0d %0d %0d %0d latency=%0d", c_00, c_01, c_10, c_11, lat);
        checks++;
        if (enable_count - en0 != 2) begin
            errors++;
            $display("FAIL stall_enables: got %0d expected 2", enable_count - en0);
        end
        checks++;
        if (lat != 7) begin
            errors++;
            $display("FAIL stall_latency: got %0d expected 7", lat);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (res_valid !== 1'b1 || {c_00, c_01, c_10, c_11} !== {20'd19, 20'd22, 20'd43, 20'd50}) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got rv=%b c=%0d %0d %0d %0d expected 1 19 22 43 50",
                         i, res_valid, c_00, c_01, c_10, c_11);
            end
        end
        accept_result();
    endtask

    task automatic test_back_to_back;
        int lat, clr0;
        clr0 = clear_count;
        start_job(2);
        send_beat(8'd1, 8'd3, 8'd5, 8'd6, 0);
        send_beat(8'd2, 8'd4, 8'd7, 8'd8, 0);
        wait_result(lat);
        accept_result();
        start_job(1);
        send_beat(8'd2, 8'd3, 8'd4, 8'd5, 0);
        wait_result(lat);
        $display("back_to_back k=1: c=%0d %0d %0d %0d latency=%0d", c_00, c_01, c_10, c_11, lat);
        checks++;
        if ({c_00, c_01, c_10, c_11} !== {20'd8, 20'd10, 20'd12, 20'd15}) begin
            errors++;
            $display("FAIL b2b_c: got %0d %0d %0d %0d expected 8 10 12 15", c_00, c_01, c_10, c_11);
        end
        checks++;
        if (lat != 3) begin
            errors++;
            $display("FAIL b2b_latency: got %0d expected 3", lat);
        end
        checks++;
        if (clear_count - clr0 != 2) begin
            errors++;
            $display("FAIL b2b_clears: got %0d expected 2", clear_count - clr0);
        end
        accept_result();
    endtask

    task automatic test_k_zero;
        int lat, or0, en0;
        or0 = op_ready_count;
        en0 = enable_count;
        op_valid = 1'b1; a_r0 = 8'd7; b_c0 = 8'd7;
        start_job(0);
        wait_result(lat);
        op_valid = 1'b0; a_r0 = '0; b_c0 = '0;
        $display("k_zero: c=%0d %0d %0d %0d latency=%0d", c_00, c_01, c_10, c_11, lat);
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL k0_latency: got %0d expected 2", lat);
        end
        checks++;
        if (op_ready_count != or0 || enable_count != en0) begin
            errors++;
            $display("FAIL k0_no_beats: got op_ready cycles=%0d enables=%0d expected 0 0",
                     op_ready_count - or0, enable_count - en0);
        end
        checks++;
        if ({c_00, c_01, c_10, c_11} !== 80'd0) begin
            errors++;
            $display("FAIL k0_c: got %0d %0d %0d %0d expected 0 0 0 0", c_00, c_01, c_10, c_11);
        end
        accept_result();
    endtask

    task automatic test_max_range;
        int lat;
        start_job(16);
        for (int i = 0; i < 16; i++) send_beat(8'd255, 8'd255, 8'd255, 8'd255, 0);
        wait_result(lat);
        $display("max k=16: c=%0d %0d %0d %0d latency=%0d", c_00, c_01, c_10, c_11, lat);
        checks++;
        if ({c_00, c_01, c_10, c_11} !== {20'd1040400, 20'd1040400, 20'd1040400, 20'd1040400}) begin
            errors++;
            $display("FAIL max_c: got %0d %0d %0d %0d expected 1040400 each", c_00, c_01, c_10, c_11);
        end
        checks++;
        if (lat != 18) begin
            errors++;
            $display("FAIL max_latency: got %0d expected 18", lat);
        end
        accept_result();
    endtask

    task automatic test_reset_mid_job;
        start_job(8);
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 0);
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 0);
        a_r0 = 8'd3; a_r1 = 8'd3; b_c0 = 8'd3; b_c1 = 8'd3;
        op_valid = 1'b1;
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if ({start_ready, op_ready, mac_enable, mac_clear, res_valid, busy} !== 6'b100000) begin
            errors++;
            $display("FAIL midreset_ctrl: got sr/or/en/clr/rv/busy=%b expected 100000",
                     {start_ready, op_ready, mac_enable, mac_clear, res_valid, busy});
        end
        checks++;
        if ({mac_a_00, mac_b_11} !== 16'd0) begin
            errors++;
            $display("FAIL midreset_ops: got a00=%0d b11=%0d expected 0 0", mac_a_00, mac_b_11);
        end
        tick();
        reset = 1'b0;
        op_valid = 1'b0; a_r0 = '0; a_r1 = '0; b_c0 = '0; b_c1 = '0;
        tick();
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got start_ready=%b busy=%b expected 1 0", start_ready, busy);
        end
        $display("reset_mid_job: start_ready=%b busy=%b", start_ready, busy);
    endtask

`ifdef MATMUL_SEQ_ABORT_EN
    task automatic test_abort;
        int en0, clr0, rv_seen;
        start_job(8);
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 0);
        send_beat(8'd1, 8'd1, 8'd1, 8'd1, 0);
        a_r0 = 8'd3; a_r1 = 8'd3; b_c0 = 8'd3; b_c1 = 8'd3;
        op_valid = 1'b1;
        abort = 1'b1;
        #1;
        checks++;
        if (mac_enable !== 1'b0 || mac_clear !== 1'b1) begin
            errors++;
            $display("FAIL abort_comb: got enable=%b clear=%b expected 0 1", mac_enable, mac_clear);
        end
        en0 = enable_count;
        clr0 = clear_count;
        tick();
        abort = 1'b0;
        op_valid = 1'b0; a_r0 = '0; a_r1 = '0; b_c0 = '0; b_c1 = '0;
        checks++;
        if (enable_count != en0 || clear_count - clr0 != 1) begin
            errors++;
            $display("FAIL abort_pulses: got enables=%0d clears=%0d expected 0 1",
                     enable_count - en0, clear_count - clr0);
        end
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got start_ready=%b busy=%b expected 1 0", start_ready, busy);
        end
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (res_valid === 1'b1) rv_seen++;
            tick();
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL abort_no_result: res_valid seen %0d cycles expected 0", rv_seen);
        end
        $display("abort: start_ready=%b busy=%b", start_ready, busy);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stalls();
        test_back_to_back();
        test_k_zero();
        test_max_range();
        test_reset_mid_job();
`ifdef MATMUL_SEQ_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
